// File: rtl/data_mem_io.sv
// Data-bus responder: 240-byte RAM plus memory-mapped pixel screen, character line,
// number display, free-running RNG and synchronised controller input.
module data_mem_io #(
  parameter logic [7:0] RNG_SEED   = 8'h01,
  parameter int         CHAR_SLOTS = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              mem_addr_bus,
  input  logic [7:0]              dout_bus,
  input  logic                    we,
  output logic [7:0]              din_bus,
  input  logic [7:0]              ctrl_in,
  input  logic [4:0]              disp_x,
  input  logic [4:0]              disp_y,
  output logic                    disp_pixel,
  output logic [5*CHAR_SLOTS-1:0] char_disp,
  output logic [7:0]              num_value,
  output logic                    num_signed,
  output logic                    num_valid
);

  localparam int PTR_W = $clog2(CHAR_SLOTS + 1);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(CHAR_SLOTS);

  localparam logic [7:0] A_PIXEL_X    = 8'd240;
  localparam logic [7:0] A_PIXEL_Y    = 8'd241;
  localparam logic [7:0] A_DRAW       = 8'd242;
  localparam logic [7:0] A_CLEAR_PIX  = 8'd243;
  localparam logic [7:0] A_LOAD_PIX   = 8'd244;
  localparam logic [7:0] A_BUF_SCREEN = 8'd245;
  localparam logic [7:0] A_CLR_SCREEN = 8'd246;
  localparam logic [7:0] A_WRITE_CHAR = 8'd247;
  localparam logic [7:0] A_BUF_CHARS  = 8'd248;
  localparam logic [7:0] A_CLR_CHARS  = 8'd249;
  localparam logic [7:0] A_SHOW_NUM   = 8'd250;
  localparam logic [7:0] A_CLR_NUM    = 8'd251;
  localparam logic [7:0] A_SIGNED     = 8'd252;
  localparam logic [7:0] A_UNSIGNED   = 8'd253;
  localparam logic [7:0] A_RNG        = 8'd254;
  localparam logic [7:0] A_CTRL       = 8'd255;
  localparam logic [7:0] IO_BASE      = 8'd240;

  logic [7:0]              ram [0:239];
  logic [4:0]              pixel_x, pixel_y;
  logic [1023:0]           work_fb, disp_fb;
  logic [5*CHAR_SLOTS-1:0] work_chars;
  logic [PTR_W-1:0]        char_ptr;
  logic [7:0]              lfsr, lfsr_next;
  logic [7:0]              ctrl_meta, ctrl_sync;
  logic [9:0]              pix_idx, scan_idx;

  assign pix_idx    = {pixel_y, pixel_x};
  assign scan_idx   = {disp_y, disp_x};
  assign disp_pixel = disp_fb[scan_idx];
  assign lfsr_next  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // RAM has no reset and keeps accepting writes even while rst is high
  always_ff @(posedge clk) begin
    if (we && (mem_addr_bus < IO_BASE))
      ram[mem_addr_bus] <= dout_bus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pixel_x    <= '0;
      pixel_y    <= '0;
      work_fb    <= '0;
      disp_fb    <= '0;
      work_chars <= '0;
      char_disp  <= '0;
      char_ptr   <= '0;
      num_value  <= '0;
      num_signed <= 1'b0;
      num_valid  <= 1'b0;
      lfsr       <= RNG_SEED;
      ctrl_meta  <= '0;
      ctrl_sync  <= '0;
    end else begin
      lfsr      <= lfsr_next;
      ctrl_meta <= ctrl_in;
      ctrl_sync <= ctrl_meta;
      if (we) begin
        case (mem_addr_bus)
          A_PIXEL_X:    pixel_x <= dout_bus[4:0];
          A_PIXEL_Y:    pixel_y <= dout_bus[4:0];
          A_DRAW:       work_fb[pix_idx] <= 1'b1;
          A_CLEAR_PIX:  work_fb[pix_idx] <= 1'b0;
          A_BUF_SCREEN: disp_fb <= work_fb;
          A_CLR_SCREEN: work_fb <= '0;
          A_WRITE_CHAR: begin
            // The pointer saturates at CHAR_SLOTS so extra writes fall on the floor
            if (char_ptr < PTR_MAX) begin
              work_chars[5*int'(char_ptr) +: 5] <= dout_bus[4:0];
              char_ptr <= char_ptr + PTR_W'(1);
            end
          end
          A_BUF_CHARS:  char_disp <= work_chars;
          A_CLR_CHARS: begin
            work_chars <= '0;
            char_ptr   <= '0;
          end
          A_SHOW_NUM: begin
            num_value <= dout_bus;
            num_valid <= 1'b1;
          end
          A_CLR_NUM:    num_valid  <= 1'b0;
          A_SIGNED:     num_signed <= 1'b1;
          A_UNSIGNED:   num_signed <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    din_bus = 8'h00;
    if (mem_addr_bus < IO_BASE) begin
      din_bus = ram[mem_addr_bus];
    end else begin
      case (mem_addr_bus)
        A_LOAD_PIX: din_bus = {7'b0, work_fb[pix_idx]};
        A_RNG:      din_bus = lfsr;
        A_CTRL:     din_bus = ctrl_sync;
        default:    din_bus = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_io.sv
// Bench for data_mem_io: directed vector table, character-line sequence, then
// random traffic checked against a behavioural model of the memory map.
module tb_data_mem_io;
  localparam int         SLOTS = 10;
  localparam logic [7:0] SEED  = 8'h01;

  logic             clk = 1'b0;
  logic             rst, we;
  logic [7:0]       mem_addr_bus, dout_bus, din_bus, ctrl_in;
  logic [4:0]       disp_x, disp_y;
  logic             disp_pixel;
  logic [5*SLOTS-1:0] char_disp;
  logic [7:0]       num_value;
  logic             num_signed, num_valid;

  always #5 clk = ~clk;

  data_mem_io #(.RNG_SEED(SEED), .CHAR_SLOTS(SLOTS)) dut (
    .clk(clk), .rst(rst), .mem_addr_bus(mem_addr_bus), .dout_bus(dout_bus), .we(we),
    .din_bus(din_bus), .ctrl_in(ctrl_in), .disp_x(disp_x), .disp_y(disp_y),
    .disp_pixel(disp_pixel), .char_disp(char_disp), .num_value(num_value),
    .num_signed(num_signed), .num_valid(num_valid)
  );

  int compared   = 0;
  int mismatched = 0;

  // Behavioural model of the memory map
  bit [7:0] ram_m [240];
  bit       ram_ok [240];
  bit       work_m [32][32];
  bit       disp_m [32][32];
  int       px_m, py_m;
  bit [4:0] wchars [$];
  bit [4:0] dchars [SLOTS];
  bit [7:0] nv_m;
  bit       ns_m, nok_m;
  bit [7:0] lfsr_m;
  bit [7:0] ctrl_last, ctrl_prev;

  typedef struct {
    bit       r, w;
    bit [7:0] a, d, c;
    bit [4:0] x, y;
    bit       cd;  bit [7:0] ed;
    bit       cp;  bit       ep;
    bit       cn;  bit [7:0] env; bit ens; bit enok;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(bit r, bit w, bit [7:0] a, bit [7:0] d, bit [7:0] c,
                              bit [4:0] x, bit [4:0] y, bit cd, bit [7:0] ed,
                              bit cp, bit ep, bit cn, bit [7:0] env, bit ens, bit enok);
    vec_t v;
    v.r = r; v.w = w; v.a = a; v.d = d; v.c = c; v.x = x; v.y = y;
    v.cd = cd; v.ed = ed; v.cp = cp; v.ep = ep;
    v.cn = cn; v.env = env; v.ens = ens; v.enok = enok;
    return v;
  endfunction

  function automatic bit [7:0] rngStep(bit [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit w, input bit [7:0] a, input bit [7:0] d,
                               input bit [7:0] c, input bit [4:0] x, input bit [4:0] y);
    rst = r; we = w; mem_addr_bus = a; dout_bus = d; ctrl_in = c; disp_x = x; disp_y = y;
  endtask

  task automatic modelEdge();
    if (we && mem_addr_bus < 8'd240) begin
      ram_m[mem_addr_bus]  = dout_bus;
      ram_ok[mem_addr_bus] = 1'b1;
    end
    if (rst) begin
      px_m = 0; py_m = 0;
      foreach (work_m[i, j]) begin work_m[i][j] = 1'b0; disp_m[i][j] = 1'b0; end
      wchars.delete();
      foreach (dchars[i]) dchars[i] = '0;
      nv_m = 0; ns_m = 0; nok_m = 0;
      lfsr_m = SEED;
      ctrl_last = 0; ctrl_prev = 0;
    end else begin
      lfsr_m    = rngStep(lfsr_m);
      ctrl_prev = ctrl_last;
      ctrl_last = ctrl_in;
      if (we) begin
        case (int'(mem_addr_bus))
          240: px_m = int'(dout_bus) % 32;
          241: py_m = int'(dout_bus) % 32;
          242: work_m[px_m][py_m] = 1'b1;
          243: work_m[px_m][py_m] = 1'b0;
          245: disp_m = work_m;
          246: foreach (work_m[i, j]) work_m[i][j] = 1'b0;
          247: if (wchars.size() < SLOTS) wchars.push_back(dout_bus[4:0]);
          248: foreach (dchars[i]) dchars[i] = (i < wchars.size()) ? wchars[i] : 5'd0;
          249: wchars.delete();
          250: begin nv_m = dout_bus; nok_m = 1'b1; end
          251: nok_m = 1'b0;
          252: ns_m = 1'b1;
          253: ns_m = 1'b0;
          default: ;
        endcase
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  function automatic logic [63:0] packChars();
    logic [63:0] p = '0;
    foreach (dchars[i]) p[i*5 +: 5] = dchars[i];
    return p;
  endfunction

  task automatic modelChecks();
    int a = int'(mem_addr_bus);
    if (a < 240) begin
      if (ram_ok[a]) checkOutput("rand_ram", din_bus, ram_m[a]);
    end else if (a == 244) checkOutput("rand_load_pixel", din_bus, {7'b0, work_m[px_m][py_m]});
    else if (a == 254)     checkOutput("rand_rng", din_bus, lfsr_m);
    else if (a == 255)     checkOutput("rand_ctrl", din_bus, ctrl_prev);
    else                   checkOutput("rand_io_zero", din_bus, 8'h00);
    checkOutput("rand_disp_pixel", disp_pixel, disp_m[disp_x][disp_y]);
    checkOutput("rand_char_disp", char_disp, packChars());
    checkOutput("rand_num", {num_value, num_signed, num_valid}, {nv_m, ns_m, nok_m});
  endtask

  initial begin
    logic [63:0] exp_chars;
    bit [7:0] c_cur;
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    vecs.push_back(mk(1, 0, 0,   0,    0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0,   8'hA5, 0,   0, 0, 0, 0,     1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 239, 8'h3C, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,   0,    0,    0, 0, 1, 8'hA5, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 239, 0,    0,    0, 0, 1, 8'h3C, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 240, 0,    0,    0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 240, 3,    0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 241, 7,    0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 242, 0,    0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 244, 0,    0,    3, 7, 1, 8'h01, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 245, 0,    0,    3, 7, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 244, 0,    0,    3, 7, 1, 8'h01, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 246, 0,    0,    3, 7, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 244, 0,    0,    3, 7, 1, 8'h00, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 240, 8'd33, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 242, 0,    0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 245, 0,    0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 244, 0,    0,    1, 7, 1, 8'h01, 1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 240, 0,    0,    3, 7, 1, 8'h00, 1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 250, 8'hFB, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 252, 0,    0,    0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 251, 0,    0,    0, 0, 0, 0,     0, 0, 1, 8'hFB, 1, 1));
    vecs.push_back(mk(0, 0, 253, 0,    0,    0, 0, 1, 8'h00, 0, 0, 1, 8'hFB, 1, 0));
    vecs.push_back(mk(1, 1, 250, 8'h55, 0,   0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 254, 0,    0,    1, 7, 1, 8'h01, 1, 0, 1, 8'h00, 0, 0));
    vecs.push_back(mk(0, 0, 254, 0,    0,    0, 0, 1, 8'h02, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 254, 0,    0,    0, 0, 1, 8'h04, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 254, 0,    0,    0, 0, 1, 8'h08, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 254, 0,    0,    0, 0, 1, 8'h11, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 254, 0,    0,    0, 0, 1, 8'h23, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 254, 0,    0,    0, 0, 1, 8'h01, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 255, 0,    8'h81, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 255, 0,    8'h81, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 255, 0,    8'h81, 0, 0, 1, 8'h81, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 255, 0,    8'h81, 0, 0, 1, 8'h81, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t t = vecs[i];
      applyStimulus(t.r, t.w, t.a, t.d, t.c, t.x, t.y);
      #3;
      if (t.cd) checkOutput($sformatf("vec%0d_din", i), din_bus, t.ed);
      if (t.cp) checkOutput($sformatf("vec%0d_pixel", i), disp_pixel, t.ep);
      if (t.cn) checkOutput($sformatf("vec%0d_num", i), {num_value, num_signed, num_valid},
                            {t.env, t.ens, t.enok});
      advance();
    end

    // Character line: saturation after ten slots, then clear without touching the display
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("chars_reset", char_disp, 64'd0);
    for (int i = 1; i <= 12; i++) begin
      applyStimulus(0, 1, 247, 8'(i), 0, 0, 0);
      advance();
    end
    applyStimulus(0, 1, 248, 0, 0, 0, 0);
    advance();
    exp_chars = '0;
    for (int k = 0; k < SLOTS; k++) exp_chars[k*5 +: 5] = 5'(k + 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("chars_saturated", char_disp, exp_chars);
    checkOutput("chars_slot9", char_disp[49:45], 5'd10);
    advance();
    applyStimulus(0, 1, 249, 0, 0, 0, 0);
    advance();
    applyStimulus(0, 1, 247, 5, 0, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("chars_held", char_disp, exp_chars);
    advance();
    applyStimulus(0, 1, 248, 0, 0, 0, 0);
    advance();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    #3;
    checkOutput("chars_after_clear", char_disp, 64'd5);
    advance();

    // Random traffic against the model
    c_cur = 8'h00;
    for (int n = 0; n < 1500; n++) begin
      bit r, w;
      bit [7:0] a, d;
      bit [4:0] x, y;
      r = ($urandom_range(0, 199) == 0);
      w = $urandom_range(0, 1) == 1;
      a = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(240, 255)) : 8'($urandom_range(0, 239));
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) c_cur = 8'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        x = 5'(px_m); y = 5'(py_m);
      end else begin
        x = 5'($urandom); y = 5'($urandom);
      end
      applyStimulus(r, w, a, d, c_cur, x, y);
      #3;
      modelChecks();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
